// File: rtl/id_pkg.sv
// Shared types for the decode-issue stage: decoder control bundle, branch kinds
// and the reset value of the registered control.
package id_pkg;

    typedef enum logic [3:0] {
        BR_NONE,
        BR_J,
        BR_JAL,
        BR_JR,
        BR_JALR,
        BR_BEQ,
        BR_BNE,
        BR_BGTZ,
        BR_BLEZ,
        BR_BLTZ,
        BR_BGEZ
    } br_type_e;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        wreg;
        logic [4:0]  wd;
        logic        rs_read;
        logic        rt_read;
        logic [31:0] imm;
        br_type_e    br_type;
    } id_ctrl_t;

    localparam id_ctrl_t INIT_CTRL = id_ctrl_t'('0);

    function automatic logic is_branch(br_type_e t);
        return t != BR_NONE;
    endfunction

    function automatic logic is_link(br_type_e t);
        return (t == BR_JAL) || (t == BR_JALR);
    endfunction

endpackage

// File: rtl/id_branch_unit.sv
// Combinational branch resolver working on already-bypassed operands.
// inst_idx carries inst[25:0]; its low 16 bits are the conditional offset.
module id_branch_unit
    import id_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [31:0]       pc,
    input  logic [25:0]       inst_idx,
    input  br_type_e          br_type,
    output logic              taken,
    output logic [31:0]       target
);

    logic [31:0] pc_plus4;
    logic [31:0] br_off;
    logic        rs_neg;
    logic        rs_zero;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{inst_idx[15]}}, inst_idx[15:0], 2'b00};
    assign rs_neg   = rs_val[DATA_W-1];
    assign rs_zero  = (rs_val == '0);

    always_comb begin
        taken  = 1'b0;
        target = pc_plus4 + br_off;
        case (br_type)
            BR_J, BR_JAL: begin
                taken  = 1'b1;
                target = {pc_plus4[31:28], inst_idx, 2'b00};
            end
            BR_JR, BR_JALR: begin
                taken  = 1'b1;
                target = 32'(rs_val);
            end
            BR_BEQ:  taken = (rs_val == rt_val);
            BR_BNE:  taken = (rs_val != rt_val);
            BR_BGTZ: taken = ~rs_neg & ~rs_zero;
            BR_BLEZ: taken = rs_neg | rs_zero;
            BR_BLTZ: taken = rs_neg;
            BR_BGEZ: taken = ~rs_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode-issue stage: bypassed operand select, load-use stall, branch resolve,
// and a registered ID/EX boundary with valid/ready on both sides.
module id_issue_stage
    import id_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    input  id_ctrl_t                  dec_i,
    input  logic [DATA_W-1:0]         rf_rdata1_i,
    input  logic [DATA_W-1:0]         rf_rdata2_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD-1:0]        fwd_load_i,
    input  logic [NUM_FWD*5-1:0]      fwd_waddr_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic                      flush_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output id_ctrl_t                  ctrl_o,
    output logic [DATA_W-1:0]         reg1_o,
    output logic [DATA_W-1:0]         reg2_o,
    output logic                      in_delay_slot_o,
    output logic                      branch_flag_o,
    output logic [31:0]               branch_to_addr_o,
    output logic [31:0]               stall_cnt_o
);

    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              rs_ld;
    logic              rt_ld;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              hazard;
    logic              fire;
    logic              br_taken;
    logic              ds;

    assign rs_addr = inst_i[25:21];
    assign rt_addr = inst_i[20:16];

    // Chain runs oldest source first so the last stage (source 0) wins.
    for (genvar k = 0; k < NUM_FWD; k++) begin : g_byp
        localparam int SRC = NUM_FWD - 1 - k;
        logic [DATA_W-1:0] rs_prev, rt_prev, rs_val, rt_val;
        logic              rs_ld_prev, rt_ld_prev, rs_ld_val, rt_ld_val;
        logic              rs_hit, rt_hit;

        if (k == 0) begin : g_base
            assign rs_prev    = rf_rdata1_i;
            assign rt_prev    = rf_rdata2_i;
            assign rs_ld_prev = 1'b0;
            assign rt_ld_prev = 1'b0;
        end else begin : g_link
            assign rs_prev    = g_byp[k-1].rs_val;
            assign rt_prev    = g_byp[k-1].rt_val;
            assign rs_ld_prev = g_byp[k-1].rs_ld_val;
            assign rt_ld_prev = g_byp[k-1].rt_ld_val;
        end

        assign rs_hit    = fwd_we_i[SRC] && (fwd_waddr_i[SRC*5 +: 5] == rs_addr);
        assign rt_hit    = fwd_we_i[SRC] && (fwd_waddr_i[SRC*5 +: 5] == rt_addr);
        assign rs_val    = rs_hit ? fwd_wdata_i[SRC*DATA_W +: DATA_W] : rs_prev;
        assign rt_val    = rt_hit ? fwd_wdata_i[SRC*DATA_W +: DATA_W] : rt_prev;
        assign rs_ld_val = rs_hit ? fwd_load_i[SRC] : rs_ld_prev;
        assign rt_ld_val = rt_hit ? fwd_load_i[SRC] : rt_ld_prev;
    end

    assign rs_fwd = g_byp[NUM_FWD-1].rs_val;
    assign rt_fwd = g_byp[NUM_FWD-1].rt_val;
    assign rs_ld  = g_byp[NUM_FWD-1].rs_ld_val;
    assign rt_ld  = g_byp[NUM_FWD-1].rt_ld_val;

    always_comb begin
        op1 = rs_fwd;
        op2 = rt_fwd;
        if (!dec_i.rs_read)      op1 = DATA_W'(dec_i.imm);
        else if (rs_addr == '0)  op1 = '0;
        if (!dec_i.rt_read)      op2 = DATA_W'(dec_i.imm);
        else if (rt_addr == '0)  op2 = '0;
    end

    assign hazard = (dec_i.rs_read && (rs_addr != '0) && rs_ld) ||
                    (dec_i.rt_read && (rt_addr != '0) && rt_ld);

    assign in_ready_o    = ~rst & ~hazard & (~out_valid_o | out_ready_i);
    assign fire          = in_valid_i & in_ready_o;
    assign branch_flag_o = fire & br_taken & ~flush_i;

    id_branch_unit #(.DATA_W(DATA_W)) u_branch (
        .rs_val   (op1),
        .rt_val   (op2),
        .pc       (pc_i),
        .inst_idx (inst_i[25:0]),
        .br_type  (dec_i.br_type),
        .taken    (br_taken),
        .target   (branch_to_addr_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o     <= 1'b0;
            ctrl_o          <= INIT_CTRL;
            reg1_o          <= '0;
            reg2_o          <= '0;
            in_delay_slot_o <= 1'b0;
            ds              <= 1'b0;
            stall_cnt_o     <= '0;
        end else begin
            if (flush_i) begin
                out_valid_o <= 1'b0;
                ds          <= 1'b0;
            end else if (fire) begin
                out_valid_o     <= 1'b1;
                ctrl_o          <= dec_i;
                reg1_o          <= is_link(dec_i.br_type) ? DATA_W'(pc_i + 32'd8) : op1;
                reg2_o          <= op2;
                in_delay_slot_o <= ds;
                ds              <= is_branch(dec_i.br_type);
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
            if (in_valid_i && hazard && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed scenarios plus randomized traffic for id_issue_stage, checked
// against a behavioural model of operand bypass, stalls, branches and delay slots.
module tb_id_issue_stage;
    import id_pkg::*;

    localparam int NF = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, flush, out_ready;
    logic [31:0] pc, inst, rf1, rf2;
    id_ctrl_t    dec;
    logic        fwe [NF];
    logic        fld [NF];
    logic [4:0]  fwa [NF];
    logic [31:0] fwd [NF];

    logic [NF-1:0]    fwe_v, fld_v;
    logic [NF*5-1:0]  fwa_v;
    logic [NF*32-1:0] fwd_v;

    always_comb begin
        fwe_v = '0;
        fld_v = '0;
        fwa_v = '0;
        fwd_v = '0;
        for (int i = 0; i < NF; i++) begin
            fwe_v[i]          = fwe[i];
            fld_v[i]          = fld[i];
            fwa_v[i*5 +: 5]   = fwa[i];
            fwd_v[i*32 +: 32] = fwd[i];
        end
    end

    logic        in_ready_o, out_valid_o, in_delay_slot_o, branch_flag_o;
    id_ctrl_t    ctrl_o;
    logic [31:0] reg1_o, reg2_o, branch_to_addr_o, stall_cnt_o;

    id_issue_stage #(.NUM_FWD(NF), .DATA_W(32)) u_dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .pc_i(pc), .inst_i(inst), .dec_i(dec),
        .rf_rdata1_i(rf1), .rf_rdata2_i(rf2),
        .fwd_we_i(fwe_v), .fwd_load_i(fld_v), .fwd_waddr_i(fwa_v), .fwd_wdata_i(fwd_v),
        .flush_i(flush), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .ctrl_o(ctrl_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .in_delay_slot_o(in_delay_slot_o), .branch_flag_o(branch_flag_o),
        .branch_to_addr_o(branch_to_addr_o), .stall_cnt_o(stall_cnt_o)
    );

    // Single-source build, fed with source 0 only.
    logic        d1_ready, d1_valid, d1_ids, d1_bf;
    id_ctrl_t    d1_ctrl;
    logic [31:0] d1_reg1, d1_reg2, d1_bt, d1_stall;

    id_issue_stage #(.NUM_FWD(1), .DATA_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(d1_ready),
        .pc_i(pc), .inst_i(inst), .dec_i(dec),
        .rf_rdata1_i(rf1), .rf_rdata2_i(rf2),
        .fwd_we_i(fwe[0]), .fwd_load_i(fld[0]), .fwd_waddr_i(fwa[0]), .fwd_wdata_i(fwd[0]),
        .flush_i(flush), .out_valid_o(d1_valid), .out_ready_i(out_ready),
        .ctrl_o(d1_ctrl), .reg1_o(d1_reg1), .reg2_o(d1_reg2),
        .in_delay_slot_o(d1_ids), .branch_flag_o(d1_bf),
        .branch_to_addr_o(d1_bt), .stall_cnt_o(d1_stall)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference model state.
    logic        m_valid, m_ds, m_ids;
    id_ctrl_t    m_ctrl;
    logic [31:0] m_reg1, m_reg2, m_stall;

    task automatic model_reset();
        m_valid = 1'b0; m_ds = 1'b0; m_ids = 1'b0;
        m_ctrl = INIT_CTRL; m_reg1 = '0; m_reg2 = '0; m_stall = '0;
    endtask

    function automatic logic [31:0] m_operand(logic rd, logic [4:0] a, logic [31:0] rf,
                                              logic [31:0] imm);
        if (!rd) return imm;
        if (a == 5'd0) return 32'd0;
        for (int i = 0; i < NF; i++)
            if (fwe[i] && fwa[i] == a) return fwd[i];
        return rf;
    endfunction

    function automatic logic m_load_hit(logic rd, logic [4:0] a);
        if (!rd || a == 5'd0) return 1'b0;
        for (int i = 0; i < NF; i++)
            if (fwe[i] && fwa[i] == a) return fld[i];
        return 1'b0;
    endfunction

    task automatic m_branch(input br_type_e t, input logic [31:0] a, input logic [31:0] b,
                            output logic tk, output logic [31:0] tgt);
        int off;
        off = $signed(inst[15:0]);
        tk  = 1'b0;
        tgt = pc + 32'd4 + 32'(off * 4);
        case (t)
            BR_J, BR_JAL: begin
                tk = 1'b1;
                tgt = ((pc + 32'd4) & 32'hF000_0000) | (32'(inst[25:0]) * 32'd4);
            end
            BR_JR, BR_JALR: begin tk = 1'b1; tgt = a; end
            BR_BEQ:  tk = (a == b);
            BR_BNE:  tk = (a != b);
            BR_BGTZ: tk = ($signed(a) > 0);
            BR_BLEZ: tk = ($signed(a) <= 0);
            BR_BLTZ: tk = ($signed(a) < 0);
            BR_BGEZ: tk = ($signed(a) >= 0);
            default: tk = 1'b0;
        endcase
    endtask

    // One clock: check combinational outputs before the edge, advance the model,
    // then check registered outputs just after the edge.
    task automatic step();
        logic [31:0] op1, op2, tgt;
        logic        hz, rdy, fire, tk, bf;
        #1;
        op1 = m_operand(dec.rs_read, inst[25:21], rf1, dec.imm);
        op2 = m_operand(dec.rt_read, inst[20:16], rf2, dec.imm);
        hz  = m_load_hit(dec.rs_read, inst[25:21]) | m_load_hit(dec.rt_read, inst[20:16]);
        rdy = !rst && !hz && (!m_valid || out_ready);
        fire = in_valid && rdy;
        m_branch(dec.br_type, op1, op2, tk, tgt);
        bf = fire && tk && !flush;
        chk("in_ready", 64'(in_ready_o), 64'(rdy));
        chk("branch_flag", 64'(branch_flag_o), 64'(bf));
        if (bf) chk("branch_target", 64'(branch_to_addr_o), 64'(tgt));
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
            m_ds = 1'b0;
        end else if (fire) begin
            m_valid = 1'b1;
            m_ctrl  = dec;
            m_reg1  = (dec.br_type == BR_JAL || dec.br_type == BR_JALR) ? pc + 32'd8 : op1;
            m_reg2  = op2;
            m_ids   = m_ds;
            m_ds    = (dec.br_type != BR_NONE);
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (in_valid && hz && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        #1;
        chk("out_valid", 64'(out_valid_o), 64'(m_valid));
        chk("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
        if (m_valid) begin
            chk("ctrl", 64'(ctrl_o), 64'(m_ctrl));
            chk("reg1", 64'(reg1_o), 64'(m_reg1));
            chk("reg2", 64'(reg2_o), 64'(m_reg2));
            chk("delay_slot", 64'(in_delay_slot_o), 64'(m_ids));
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        pc = 32'h0; inst = 32'h0; rf1 = 32'h0; rf2 = 32'h0;
        dec = INIT_CTRL;
        for (int i = 0; i < NF; i++) begin
            fwe[i] = 1'b0; fld[i] = 1'b0; fwa[i] = 5'd0; fwd[i] = 32'h0;
        end
    endtask

    task automatic plain_op(logic [4:0] rs, logic [4:0] rt);
        dec = INIT_CTRL;
        dec.aluop = 8'h21; dec.alusel = 3'd1; dec.wreg = 1'b1; dec.wd = 5'd9;
        dec.rs_read = 1'b1; dec.rt_read = 1'b1;
        inst = {6'h00, rs, rt, 5'd9, 11'h021};
        rf1 = 32'h0000_1111; rf2 = 32'h0000_2222;
    endtask

    task automatic rand_inputs();
        in_valid = ($urandom_range(0, 9) < 8);
        flush    = ($urandom_range(0, 19) == 0);
        out_ready = ($urandom_range(0, 9) < 7);
        pc   = $urandom() & 32'hFFFF_FFFC;
        inst = $urandom();
        inst[25:21] = 5'($urandom_range(0, 7));
        inst[20:16] = 5'($urandom_range(0, 7));
        rf1 = $urandom();
        rf2 = ($urandom_range(0, 3) == 0) ? rf1 : $urandom();
        dec.aluop   = 8'($urandom());
        dec.alusel  = 3'($urandom());
        dec.wreg    = 1'($urandom());
        dec.wd      = 5'($urandom());
        dec.rs_read = ($urandom_range(0, 3) != 0);
        dec.rt_read = ($urandom_range(0, 3) != 0);
        dec.imm     = $urandom();
        dec.br_type = ($urandom_range(0, 1) == 0) ? BR_NONE
                                                  : br_type_e'(4'($urandom_range(1, 10)));
        for (int i = 0; i < NF; i++) begin
            fwe[i] = 1'($urandom());
            fld[i] = ($urandom_range(0, 5) == 0);
            fwa[i] = 5'($urandom_range(0, 7));
            fwd[i] = $urandom();
        end
    endtask

    task automatic check_reset_zero(string tag);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_ctrl"},  64'(ctrl_o), 64'd0);
        chk({tag, "_reg1"},  64'(reg1_o), 64'd0);
        chk({tag, "_reg2"},  64'(reg2_o), 64'd0);
        chk({tag, "_ids"},   64'(in_delay_slot_o), 64'd0);
        chk({tag, "_stall"}, 64'(stall_cnt_o), 64'd0);
        chk({tag, "_ready"}, 64'(in_ready_o), 64'd0);
        chk({tag, "_bflag"}, 64'(branch_flag_o), 64'd0);
    endtask

    logic [31:0] hold_reg1;
    id_ctrl_t    hold_ctrl;

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #2;
        check_reset_zero("reset");
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Source 0 beats source 2 on the same register.
        idle_inputs();
        in_valid = 1'b1;
        inst = {6'h0d, 5'd3, 5'd4, 16'h00FF};
        dec.aluop = 8'h25; dec.alusel = 3'd1; dec.wreg = 1'b1; dec.wd = 5'd4;
        dec.rs_read = 1'b1; dec.imm = 32'h0000_00FF;
        rf1 = 32'hDEAD_0003;
        fwe[0] = 1'b1; fwa[0] = 5'd3; fwd[0] = 32'h0000_1234;
        fwe[2] = 1'b1; fwa[2] = 5'd3; fwd[2] = 32'h0000_0009;
        step();
        chk("ori_fwd_reg1", 64'(reg1_o), 64'h1234);
        chk("ori_fwd_reg2_imm", 64'(reg2_o), 64'hFF);
        chk("nf1_reg1", 64'(d1_reg1), 64'h1234);
        chk("nf1_valid", 64'(d1_valid), 64'd1);
        idle_inputs();
        step();

        // Load-use on $5 stalls one cycle, then takes the loaded data.
        plain_op(5'd6, 5'd5);
        in_valid = 1'b1;
        fwe[0] = 1'b1; fld[0] = 1'b1; fwa[0] = 5'd5; fwd[0] = 32'hBAD0_BAD0;
        step();
        chk("lu_ready", 64'(in_ready_o), 64'd0);
        chk("lu_stall_cnt", 64'(stall_cnt_o), 64'd1);
        fld[0] = 1'b0; fwd[0] = 32'h0000_0055;
        step();
        chk("lu_reg2", 64'(reg2_o), 64'h55);
        chk("lu_stall_hold", 64'(stall_cnt_o), 64'd1);

        // BEQ taken; the following instruction is its delay slot.
        idle_inputs();
        in_valid = 1'b1; pc = 32'h0000_0100;
        inst = {6'h04, 5'd1, 5'd2, 16'h0004};
        dec.rs_read = 1'b1; dec.rt_read = 1'b1; dec.imm = 32'h4; dec.br_type = BR_BEQ;
        rf1 = 32'h77; rf2 = 32'h77;
        #1;
        chk("beq_flag", 64'(branch_flag_o), 64'd1);
        chk("beq_target", 64'(branch_to_addr_o), 64'h114);
        step();
        plain_op(5'd1, 5'd2); in_valid = 1'b1; pc = 32'h104;
        step();
        chk("beq_slot_ids", 64'(in_delay_slot_o), 64'd1);
        pc = 32'h108;
        step();
        chk("beq_after_slot_ids", 64'(in_delay_slot_o), 64'd0);

        // JAL target and link value.
        idle_inputs();
        in_valid = 1'b1; pc = 32'hBFC0_0000;
        inst = {6'h03, 26'h000_0100};
        dec.wreg = 1'b1; dec.wd = 5'd31; dec.br_type = BR_JAL;
        #1;
        chk("jal_target", 64'(branch_to_addr_o), 64'hB000_0400);
        step();
        chk("jal_link", 64'(reg1_o), 64'hBFC0_0008);

        // Backpressure holds everything; flush then beats the pending fire.
        plain_op(5'd1, 5'd2); in_valid = 1'b1; out_ready = 1'b0; pc = 32'hBFC0_0004;
        hold_reg1 = reg1_o; hold_ctrl = ctrl_o;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_reg1", 64'(reg1_o), 64'(hold_reg1));
            chk("bp_ctrl", 64'(ctrl_o), 64'(hold_ctrl));
            chk("bp_valid", 64'(out_valid_o), 64'd1);
        end
        flush = 1'b1; out_ready = 1'b1;
        step();
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        flush = 1'b0;
        step();
        chk("flush_ds_cleared", 64'(in_delay_slot_o), 64'd0);

        for (int n = 0; n < 600; n++) begin
            rand_inputs();
            step();
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        rand_inputs();
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        dec.br_type = BR_J;
        #2 rst = 1'b1;
        #1;
        check_reset_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 100; n++) begin
            rand_inputs();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
